// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): radix-2 restoring, one quotient
// bit per clock, with single-cycle fast paths for divide-by-zero and signed overflow.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic            START,
    input  logic            FLUSH,
    input  logic [1:0]      OP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic              rem_sel_reg, rem_sel_next;
    logic              neg_q_reg, neg_q_next;
    logic              neg_r_reg, neg_r_next;
    logic [XLEN-1:0]   dvd_reg, dvd_next;
    logic [XLEN-1:0]   dvs_reg, dvs_next;
    logic [XLEN-1:0]   rem_reg, rem_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [XLEN-1:0]   result_reg, result_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    logic              signed_op;
    logic              div_zero;
    logic              overflow;
    logic              accept;
    logic [XLEN:0]     rem_wide;
    logic [XLEN:0]     rem_sub;
    logic              rem_ge;
    logic [XLEN-1:0]   quot_fixed;
    logic [XLEN-1:0]   rem_fixed;

    always_comb begin
        signed_op = ~OP[0];
        div_zero  = (DATA2 == '0);
        overflow  = signed_op && (DATA1 == MIN_NEG) && (DATA2 == '1);
        accept    = START && !FLUSH && ((state_reg == IDLE) || (state_reg == FIN));

        // The shifted partial remainder can need XLEN+1 bits when the divisor
        // magnitude has its MSB set, so compare and subtract one bit wider.
        rem_wide  = {rem_reg, dvd_reg[XLEN-1]};
        rem_ge    = (rem_wide >= {1'b0, dvs_reg});
        rem_sub   = rem_wide - {1'b0, dvs_reg};

        quot_fixed = neg_q_reg ? (~dvd_reg + 1'b1) : dvd_reg;
        rem_fixed  = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
    end

    always_comb begin
        state_next   = state_reg;
        rem_sel_next = rem_sel_reg;
        neg_q_next   = neg_q_reg;
        neg_r_next   = neg_r_reg;
        dvd_next     = dvd_reg;
        dvs_next     = dvs_reg;
        rem_next     = rem_reg;
        cnt_next     = cnt_reg;
        result_next  = result_reg;

        case (state_reg)
            IDLE, FIN: begin
                state_next = IDLE;
                if (accept) begin
                    if (div_zero) begin
                        result_next = OP[1] ? DATA1 : '1;
                        state_next  = FIN;
                    end else if (overflow) begin
                        result_next = OP[1] ? '0 : MIN_NEG;
                        state_next  = FIN;
                    end else begin
                        rem_sel_next = OP[1];
                        neg_q_next   = signed_op && (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
                        neg_r_next   = signed_op && DATA1[XLEN-1];
                        dvd_next     = (signed_op && DATA1[XLEN-1]) ? (~DATA1 + 1'b1) : DATA1;
                        dvs_next     = (signed_op && DATA2[XLEN-1]) ? (~DATA2 + 1'b1) : DATA2;
                        rem_next     = '0;
                        cnt_next     = '0;
                        state_next   = CALC;
                    end
                end
            end
            CALC: begin
                if (FLUSH) begin
                    state_next = IDLE;
                end else begin
                    // Quotient bits shift into the vacated LSBs of the dividend.
                    dvd_next = {dvd_reg[XLEN-2:0], rem_ge};
                    rem_next = rem_ge ? rem_sub[XLEN-1:0] : rem_wide[XLEN-1:0];
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ITER) begin
                        state_next = FIX;
                    end
                end
            end
            FIX: begin
                if (FLUSH) begin
                    state_next = IDLE;
                end else begin
                    result_next = rem_sel_reg ? rem_fixed : quot_fixed;
                    state_next  = FIN;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next == CALC) || (state_next == FIX);
        done_next = (state_next == FIN);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_reg   <= IDLE;
            rem_sel_reg <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            dvd_reg     <= '0;
            dvs_reg     <= '0;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            result_reg  <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rem_sel_reg <= rem_sel_next;
            neg_q_reg   <= neg_q_next;
            neg_r_reg   <= neg_r_next;
            dvd_reg     <= dvd_next;
            dvs_reg     <= dvs_next;
            rem_reg     <= rem_next;
            cnt_reg     <= cnt_next;
            result_reg  <= result_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign BUSY   = busy_reg;
    assign DONE   = done_reg;
    assign RESULT = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected result and DONE cycle,
// a negedge monitor pops and compares on every DONE pulse.
module tb_div_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam int LAT_FULL = 34;
    localparam int LAT_FAST = 1;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        START = 1'b0;
    logic        FLUSH = 1'b0;
    logic [1:0]  OP = 2'b00;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    div_unit #(.XLEN(32)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .START  (START),
        .FLUSH  (FLUSH),
        .OP     (OP),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t  sb[$];
    string names[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RESETN && DONE) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got DONE with result=%h at cycle %0d, required no DONE", RESULT, cyc);
            end else begin
                exp_t  e;
                string n;
                e = sb.pop_front();
                n = names.pop_front();
                if (RESULT !== e.res || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL %s: got result=%h cycle=%0d, required result=%h cycle=%0d",
                             n, RESULT, cyc, e.res, e.cyc);
                end else begin
                    $display("[TB] %s result=%h cycle=%0d ok", n, RESULT, cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end else begin
            $display("[TB] %s = %h ok", name, got);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Raw START pulse with no scoreboard entry; operands scrambled after the edge.
    task automatic pulse(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        OP = op; DATA1 = a; DATA2 = b; START = 1'b1;
        tick(1);
        START = 1'b0;
        DATA1 = $urandom;
        DATA2 = $urandom;
        OP    = 2'($urandom_range(0, 3));
    endtask

    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat);
        exp_t e;
        e.res = res;
        e.cyc = cyc + lat;
        sb.push_back(e);
        names.push_back(name);
        pulse(op, a, b);
        check({name, "_busy"}, {31'b0, BUSY}, (lat > 1) ? 32'd1 : 32'd0);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: got %0d results pending after %0d cycles, required 0", name, sb.size(), n);
            sb.delete();
            names.delete();
        end
    endtask

    initial begin
        int n;
        int t0;

        tick(3);
        check("reset_busy", {31'b0, BUSY}, 32'd0);
        check("reset_done", {31'b0, DONE}, 32'd0);
        check("reset_result", RESULT, 32'd0);
        RESETN = 1'b1;
        tick(2);

        // Basic DIV with BUSY-duration count.
        issue("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, LAT_FULL);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (BUSY) n++;
            else break;
        end
        check("div_busy_cycles", n, 32'd33);
        wait_done("div_100_7");

        issue("rem_100_7", OP_REM, 32'd100, 32'd7, 32'd2, LAT_FULL);
        wait_done("rem_100_7");
        issue("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_FULL);
        wait_done("rem_m7_2");
        issue("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_FULL);
        wait_done("div_m7_2");
        issue("divu_max_2", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, LAT_FULL);
        wait_done("divu_max_2");
        issue("remu_max_16", OP_REMU, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, LAT_FULL);
        wait_done("remu_max_16");
        issue("div_m100_m7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, LAT_FULL);
        wait_done("div_m100_m7");
        issue("rem_m100_m7", OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, LAT_FULL);
        wait_done("rem_m100_m7");
        issue("divu_max_maxm1", OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, LAT_FULL);
        wait_done("divu_max_maxm1");
        issue("remu_max_maxm1", OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, LAT_FULL);
        wait_done("remu_max_maxm1");

        // Divide by zero fast path, issued back-to-back one per cycle.
        issue("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_FAST);
        issue("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_FAST);
        issue("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, LAT_FAST);
        issue("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, LAT_FAST);
        wait_done("div_zero");

        // Signed overflow.
        issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FAST);
        wait_done("div_ovf");
        issue("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_FAST);
        wait_done("rem_ovf");
        issue("divu_ovf_ops", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_FULL);
        wait_done("divu_ovf_ops");
        issue("remu_ovf_ops", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FULL);
        wait_done("remu_ovf_ops");

        // Reset at CALC iteration 10.
        pulse(OP_DIV, 32'd100, 32'd7);
        tick(10);
        RESETN = 1'b0;
        tick(1);
        RESETN = 1'b1;
        check("rst_abort_busy", {31'b0, BUSY}, 32'd0);
        check("rst_abort_done", {31'b0, DONE}, 32'd0);
        check("rst_abort_result", RESULT, 32'd0);
        tick(40);

        // Flush mid-CALC keeps the previous result.
        issue("pre_flush_div", OP_DIV, 32'd100, 32'd7, 32'd14, LAT_FULL);
        wait_done("pre_flush_div");
        pulse(OP_DIV, 32'd200, 32'd3);
        tick(10);
        FLUSH = 1'b1;
        tick(1);
        FLUSH = 1'b0;
        check("flush_busy", {31'b0, BUSY}, 32'd0);
        check("flush_done", {31'b0, DONE}, 32'd0);
        check("flush_result", RESULT, 32'd14);
        tick(40);

        // FLUSH and START together: request dropped.
        FLUSH = 1'b1;
        pulse(OP_DIV, 32'd9, 32'd0);
        FLUSH = 1'b0;
        check("flush_start_busy", {31'b0, BUSY}, 32'd0);
        check("flush_start_done", {31'b0, DONE}, 32'd0);
        tick(5);

        // START during CALC is ignored.
        issue("repulse_first", OP_DIV, 32'd100, 32'd7, 32'd14, LAT_FULL);
        tick(5);
        pulse(OP_REM, 32'd50, 32'd5);
        wait_done("repulse_first");
        tick(40);

        // START in the FIN cycle is accepted.
        t0 = cyc;
        issue("b2b_first", OP_DIVU, 32'd1000, 32'd10, 32'd100, LAT_FULL);
        n = 0;
        while (cyc < t0 + LAT_FULL && n < 100) begin
            tick(1);
            n++;
        end
        issue("b2b_second", OP_REMU, 32'd1000, 32'd7, 32'd6, LAT_FULL);
        wait_done("b2b");
        tick(5);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

endmodule
